sdram_sched: RTL and testbench
==============================

SDRAM_SCHED -- requirements
Module: sdram_sched

Interface
REQ-001 SHALL have parameter REFRESH_INTERVAL, default 1560, meaning cycles between refresh requests.
REQ-002 SHALL have parameter T_RFC, default 7, meaning NOP cycles after a scheduler-issued auto-refresh.
REQ-003 SHALL have parameter GRANT_LIMIT, default 256, meaning max grant cycles while the other requester waits.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on posedge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port init_done  in  1  SDRAM power-up init complete.
REQ-007 SHALL have ports rd_req, wr_req  in  1 each  requester wants read or write service.
REQ-008 SHALL have ports rd_ready, wr_ready  in  1 each  engine idle, with its row precharged.
REQ-009 SHALL have ports rd_command, wr_command  in  3 each  engine command codes.
REQ-010 SHALL have ports rd_addr, wr_addr  in  12 each  engine address buses.
REQ-011 SHALL have ports rd_bank, wr_bank  in  2 each  engine bank selects.
REQ-012 SHALL have ports rd_en, wr_en  out  1 each  engine enable (grant).
REQ-013 SHALL have port auto_refresh  out  1  one-cycle refresh pulse to the granted engine.
REQ-014 SHALL have ports command  out  3, addr  out  12, bank  out  2  SDRAM pin buses.
REQ-015 SHALL have port busy  out  1  state not IDLE.
REQ-016 SHALL have port ref_overrun  out  1  sticky: a refresh interval expired while the previous refresh was still pending.

Function
REQ-017 SHALL implement states IDLE, READ, READ_DRAIN, WRITE, WRITE_DRAIN, REFRESH, REFRESH_WAIT.
REQ-018 SHALL run a refresh counter from REFRESH_INTERVAL-1 down to 0, then reload it and set ref_pending; it counts in all states once init_done=1.
REQ-019 SHALL hold the state in IDLE, outputs at reset values, while init_done=0.
REQ-020 SHALL use this IDLE priority: ref_pending, then requests; if rd_req and wr_req are both high, grant opposite of last_grant; otherwise grant the single requester.
REQ-021 SHALL move IDLE->REFRESH when ref_pending=1, even if a request arrives in the same cycle.
REQ-022 SHALL drive command=SDRAM_CMD_AR for one cycle in REFRESH, clear ref_pending, load the wait counter with T_RFC, and go to REFRESH_WAIT.
REQ-023 SHALL drive NOP in REFRESH_WAIT and return to IDLE when the wait counter reaches 0; addr=0, bank=0 throughout.
REQ-024 SHALL, on a read grant, set rd_en=1 on the next edge, set last_grant=read, and clear the grant counter.
REQ-025 SHALL, in READ, pulse auto_refresh exactly once when ref_pending=1 and clear ref_pending; the engine performs the refresh.
REQ-026 SHALL move READ->READ_DRAIN with rd_en=0 when rd_req=0, or when wr_req=1 and the grant counter reaches GRANT_LIMIT-1.
REQ-027 SHALL move READ_DRAIN->IDLE when rd_ready=1; ref_pending set during drain waits for IDLE.
REQ-028 SHALL make WRITE/WRITE_DRAIN mirror REQ-024..027 with wr_* signals.
REQ-029 SHALL register the command mux with 1-cycle latency: READ/READ_DRAIN pass rd_command/rd_addr/rd_bank; WRITE/WRITE_DRAIN pass wr_*; REFRESH per REQ-022; all other states drive NOP, 0, 0.
REQ-030 SHALL never assert rd_en and wr_en in the same cycle.
REQ-031 SHALL set ref_overrun when the counter expires while ref_pending=1; the flag clears only on reset.
REQ-032 SHALL saturate the grant counter at GRANT_LIMIT-1 while the other requester is idle.

Reset
REQ-033 SHALL apply reset at rst=0 on posedge: state=IDLE, command=SDRAM_CMD_NOP, addr=0, bank=0, rd_en=0, wr_en=0, auto_refresh=0, busy=0, ref_overrun=0, ref_pending=0, last_grant=write, refresh counter reloaded.
REQ-034 SHALL, when reset is asserted mid-grant or mid-refresh, force the REQ-033 values on that edge without draining.

Verification
REQ-035 SHALL cover: rst released, init_done=1, rd_req and wr_req both high in the same cycle -> rd_en=1 first; after rd_req=0 and rd_ready=1, wr_en=1.
REQ-036 SHALL cover: idle for REFRESH_INTERVAL cycles -> command=AR for exactly 1 cycle, then 7 NOP cycles, then IDLE.
REQ-037 SHALL cover: rd_req held, refresh expires -> one auto_refresh pulse, rd_en stays 1, no scheduler AR.
REQ-038 SHALL cover: rd_req held and wr_req raised -> rd_en drops after 256 grant cycles, then wr_en rises after rd_ready=1.
REQ-039 SHALL cover: init_done=0 for 2*REFRESH_INTERVAL cycles -> no grants, ref_overrun=0; with init_done=1 and refresh blocked for 2 intervals (long drain) -> ref_overrun=1.
REQ-040 SHALL cover: rst=0 during WRITE -> wr_en=0 and command=NOP on the same edge.

Source files
------------

// File: rtl/sdram_sched.sv
// SDRAM access scheduler: arbitrates a read and a write engine onto one
// SDRAM command bus and inserts periodic auto-refresh cycles.
module sdram_sched #(
  parameter int REFRESH_INTERVAL = 1560,
  parameter int T_RFC            = 7,
  parameter int GRANT_LIMIT      = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_done,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic        rd_ready,
  input  logic        wr_ready,
  input  logic [2:0]  rd_command,
  input  logic [2:0]  wr_command,
  input  logic [11:0] rd_addr,
  input  logic [11:0] wr_addr,
  input  logic [1:0]  rd_bank,
  input  logic [1:0]  wr_bank,
  output logic        rd_en,
  output logic        wr_en,
  output logic        auto_refresh,
  output logic [2:0]  command,
  output logic [11:0] addr,
  output logic [1:0]  bank,
  output logic        busy,
  output logic        ref_overrun
);

  localparam logic [2:0] SDRAM_CMD_NOP = 3'b111;
  localparam logic [2:0] SDRAM_CMD_AR  = 3'b001;

  localparam int RW = $clog2(REFRESH_INTERVAL + 1);
  localparam int GW = $clog2(GRANT_LIMIT + 1);
  localparam int TW = $clog2(T_RFC + 1);

  localparam logic [RW-1:0] RMAX = RW'(REFRESH_INTERVAL - 1);
  localparam logic [GW-1:0] GMAX = GW'(GRANT_LIMIT - 1);
  localparam logic [TW-1:0] TRFC = TW'(T_RFC);

  typedef enum logic [2:0] {
    IDLE, READ, READ_DRAIN, WRITE,
    WRITE_DRAIN, REFRESH, REFRESH_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [TW-1:0] wcnt_q, wcnt_d;
  logic        pend_q, pend_d;
  logic        ovr_q, ovr_d;
  logic        lastw_q, lastw_d;
  logic        arf_q, arf_d;
  logic        rd_en_q, rd_en_d;
  logic        wr_en_q, wr_en_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [11:0] addr_q, addr_d;
  logic [1:0]  bank_q, bank_d;
  logic        expire, clr, go_rd, go_wr;

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    gcnt_d  = gcnt_q;
    wcnt_d  = wcnt_q;
    lastw_d = lastw_q;
    arf_d   = 1'b0;
    expire  = 1'b0;
    clr     = 1'b0;
    go_rd   = 1'b0;
    go_wr   = 1'b0;

    if (init_done) begin
      if (rcnt_q == '0) begin
        rcnt_d = RMAX;
        expire = 1'b1;
      end else begin
        rcnt_d = rcnt_q - 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (pend_q) begin
            state_d = REFRESH;
          end else if (rd_req && wr_req) begin
            go_rd = lastw_q;
            go_wr = !lastw_q;
          end else begin
            go_rd = rd_req;
            go_wr = wr_req;
          end
        end
        READ: begin
          if (gcnt_q != GMAX) gcnt_d = gcnt_q + 1'b1;
          if (!rd_req || (wr_req && gcnt_q == GMAX)) begin
            state_d = READ_DRAIN;
          end else if (pend_q) begin
            arf_d = 1'b1;
            clr   = 1'b1;
          end
        end
        READ_DRAIN: if (rd_ready) state_d = IDLE;
        WRITE: begin
          if (gcnt_q != GMAX) gcnt_d = gcnt_q + 1'b1;
          if (!wr_req || (rd_req && gcnt_q == GMAX)) begin
            state_d = WRITE_DRAIN;
          end else if (pend_q) begin
            arf_d = 1'b1;
            clr   = 1'b1;
          end
        end
        WRITE_DRAIN: if (wr_ready) state_d = IDLE;
        REFRESH: begin
          clr     = 1'b1;
          wcnt_d  = TRFC;
          state_d = REFRESH_WAIT;
        end
        REFRESH_WAIT: begin
          wcnt_d = wcnt_q - 1'b1;
          if (wcnt_q <= 1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (go_rd) begin
        state_d = READ;
        lastw_d = 1'b0;
        gcnt_d  = '0;
      end else if (go_wr) begin
        state_d = WRITE;
        lastw_d = 1'b1;
        gcnt_d  = '0;
      end
    end else begin
      state_d = IDLE;
    end

    pend_d = (pend_q && !clr) || expire;
    ovr_d  = ovr_q || (expire && pend_q && !clr);

    rd_en_d = (state_d == READ);
    wr_en_d = (state_d == WRITE);

    cmd_d  = SDRAM_CMD_NOP;
    addr_d = '0;
    bank_d = '0;
    unique case (state_q)
      READ, READ_DRAIN: begin
        cmd_d  = rd_command;
        addr_d = rd_addr;
        bank_d = rd_bank;
      end
      WRITE, WRITE_DRAIN: begin
        cmd_d  = wr_command;
        addr_d = wr_addr;
        bank_d = wr_bank;
      end
      REFRESH: cmd_d = SDRAM_CMD_AR;
      default: cmd_d = SDRAM_CMD_NOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      rcnt_q  <= RMAX;
      gcnt_q  <= '0;
      wcnt_q  <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      lastw_q <= 1'b1;
      arf_q   <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      cmd_q   <= SDRAM_CMD_NOP;
      addr_q  <= '0;
      bank_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      gcnt_q  <= gcnt_d;
      wcnt_q  <= wcnt_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      lastw_q <= lastw_d;
      arf_q   <= arf_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      bank_q  <= bank_d;
    end
  end

  assign rd_en        = rd_en_q;
  assign wr_en        = wr_en_q;
  assign auto_refresh = arf_q;
  assign command      = cmd_q;
  assign addr         = addr_q;
  assign bank         = bank_q;
  assign busy         = (state_q != IDLE);
  assign ref_overrun  = ovr_q;

endmodule

// File: tb/tb_sdram_sched.sv
// Directed bench for sdram_sched: vector table for arbitration and
// command muxing, hand sequences for refresh, fairness and reset.
module tb_sdram_sched;

  localparam int RI = 400;
  localparam int TR = 7;
  localparam int GL = 256;
  localparam logic [2:0] NOP = 3'b111;
  localparam logic [2:0] AR  = 3'b001;

  logic        clk, rst, init_done;
  logic        rd_req, wr_req, rd_ready, wr_ready;
  logic [2:0]  rd_command, wr_command;
  logic [11:0] rd_addr, wr_addr;
  logic [1:0]  rd_bank, wr_bank;
  logic        rd_en, wr_en, auto_refresh, busy, ref_overrun;
  logic [2:0]  command;
  logic [11:0] addr;
  logic [1:0]  bank;

  int checks = 0;
  int failures = 0;

  sdram_sched #(
    .REFRESH_INTERVAL(RI), .T_RFC(TR), .GRANT_LIMIT(GL)
  ) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .rd_req(rd_req), .wr_req(wr_req),
    .rd_ready(rd_ready), .wr_ready(wr_ready),
    .rd_command(rd_command), .wr_command(wr_command),
    .rd_addr(rd_addr), .wr_addr(wr_addr),
    .rd_bank(rd_bank), .wr_bank(wr_bank),
    .rd_en(rd_en), .wr_en(wr_en),
    .auto_refresh(auto_refresh),
    .command(command), .addr(addr), .bank(bank),
    .busy(busy), .ref_overrun(ref_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rd, wr, rrdy, wrdy;
    logic [2:0] rc, wc;
    logic [11:0] ra, wa;
    logic [1:0] rb, wb;
    logic erd, ewr, ebusy;
    logic [2:0] ec;
    logic [11:0] ea;
    logic [1:0] eb;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(
    input int rd, input int wr, input int rrdy, input int wrdy,
    input int rc, input int ra, input int rb,
    input int wc, input int wa, input int wb,
    input int erd, input int ewr, input int ebusy,
    input int ec, input int ea, input int eb);
    vec_t v;
    v.rd = 1'(rd); v.wr = 1'(wr);
    v.rrdy = 1'(rrdy); v.wrdy = 1'(wrdy);
    v.rc = 3'(rc); v.ra = 12'(ra); v.rb = 2'(rb);
    v.wc = 3'(wc); v.wa = 12'(wa); v.wb = 2'(wb);
    v.erd = 1'(erd); v.ewr = 1'(ewr); v.ebusy = 1'(ebusy);
    v.ec = 3'(ec); v.ea = 12'(ea); v.eb = 2'(eb);
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_req = 0; wr_req = 0; rd_ready = 0; wr_ready = 0;
    rd_command = NOP; wr_command = NOP;
    rd_addr = '0; wr_addr = '0; rd_bank = '0; wr_bank = '0;
  endtask

  task automatic do_reset(input logic init);
    rst = 0;
    init_done = init;
    idle_inputs();
    step();
    step();
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cmd", 32'(command), 32'(NOP));
    chk("rst_addr", 32'(addr), 0);
    chk("rst_ovr", 32'(ref_overrun), 0);
    chk("rst_arf", 32'(auto_refresh), 0);
    rst = 1;
  endtask

  initial begin
    int n, bad, bad2, pulses, at;
    rst = 0;
    init_done = 0;
    idle_inputs();

    tbl[0]  = mk(1,1,0,0, 0,0,0, 0,0,0, 1,0,1, NOP,0,0);
    tbl[1]  = mk(1,1,0,0, 3,'h0a5,1, 4,'h0f0,2, 1,0,1, 3,'h0a5,1);
    tbl[2]  = mk(0,1,0,0, 5,'h123,2, 6,'h456,3, 0,0,1, 5,'h123,2);
    tbl[3]  = mk(0,1,0,0, 6,'h3c3,3, 0,0,0, 0,0,1, 6,'h3c3,3);
    tbl[4]  = mk(0,1,1,0, 2,'h777,0, 1,'h888,1, 0,0,0, 2,'h777,0);
    tbl[5]  = mk(0,1,0,0, 0,0,0, 5,'h999,1, 0,1,1, NOP,0,0);
    tbl[6]  = mk(1,1,0,0, 3,'h111,1, 4,'habc,2, 0,1,1, 4,'habc,2);
    tbl[7]  = mk(1,0,0,0, 3,'h111,1, 0,'h5a5,1, 0,0,1, 0,'h5a5,1);
    tbl[8]  = mk(1,0,0,1, 3,'h111,1, 3,'hfff,3, 0,0,0, 3,'hfff,3);
    tbl[9]  = mk(1,1,0,0, 0,0,0, 0,0,0, 1,0,1, NOP,0,0);
    tbl[10] = mk(0,1,0,0, 7,'h001,0, 2,'h002,2, 0,0,1, 7,'h001,0);
    tbl[11] = mk(0,1,1,0, 1,'h002,1, 2,'h003,2, 0,0,0, 1,'h002,1);
    tbl[12] = mk(1,1,0,0, 0,0,0, 0,0,0, 0,1,1, NOP,0,0);

    do_reset(1'b1);
    for (int i = 0; i < 13; i++) begin
      rd_req = tbl[i].rd; wr_req = tbl[i].wr;
      rd_ready = tbl[i].rrdy; wr_ready = tbl[i].wrdy;
      rd_command = tbl[i].rc; rd_addr = tbl[i].ra;
      rd_bank = tbl[i].rb;
      wr_command = tbl[i].wc; wr_addr = tbl[i].wa;
      wr_bank = tbl[i].wb;
      step();
      chk($sformatf("v%0d_rd_en", i), 32'(rd_en), 32'(tbl[i].erd));
      chk($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(tbl[i].ewr));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].ebusy));
      chk($sformatf("v%0d_cmd", i), 32'(command), 32'(tbl[i].ec));
      chk($sformatf("v%0d_addr", i), 32'(addr), 32'(tbl[i].ea));
      chk($sformatf("v%0d_bank", i), 32'(bank), 32'(tbl[i].eb));
    end

    // Idle refresh; a read arriving with the refresh pending must wait.
    do_reset(1'b1);
    bad = 0;
    for (int k = 1; k <= RI; k++) begin
      step();
      if (busy || command !== NOP) bad++;
    end
    chk("ref_idle_before", 32'(bad), 0);
    rd_req = 1;
    step();
    chk("ref_first_busy", 32'(busy), 1);
    chk("ref_beats_req", 32'(rd_en), 0);
    step();
    chk("ref_ar_cmd", 32'(command), 32'(AR));
    chk("ref_ar_rd_en", 32'(rd_en), 0);
    n = 1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (command !== NOP) bad++;
      if (!busy) break;
      n++;
    end
    chk("ref_wait_len", 32'(n), 32'(TR));
    chk("ref_wait_nop", 32'(bad), 0);
    step();
    chk("ref_then_grant", 32'(rd_en), 1);

    // Refresh expiring mid-read goes to the engine.
    do_reset(1'b1);
    rd_req = 1;
    pulses = 0; at = -1; bad = 0; bad2 = 0;
    for (int k = 1; k <= RI + 20; k++) begin
      step();
      if (!rd_en) bad++;
      if (command === AR) bad2++;
      if (auto_refresh) begin
        pulses++;
        at = k;
      end
    end
    chk("arf_pulses", 32'(pulses), 1);
    chk("arf_edge", 32'(at), 32'(RI + 1));
    chk("arf_rd_en_held", 32'(bad), 0);
    chk("arf_no_sched_ar", 32'(bad2), 0);

    // Grant limit with both requesters active.
    do_reset(1'b1);
    rd_req = 1; wr_req = 1;
    n = 0;
    for (int k = 0; k < GL + 10; k++) begin
      step();
      if (!rd_en) break;
      n++;
    end
    chk("glim_rd_cycles", 32'(n), 32'(GL));
    chk("glim_wr_wait", 32'(wr_en), 0);
    rd_ready = 1;
    bad = 1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (rd_en && wr_en) bad2 = 99;
      if (wr_en) begin
        bad = 0;
        break;
      end
    end
    chk("glim_wr_grant", 32'(bad), 0);
    chk("glim_rd_off", 32'(rd_en), 0);

    // Held in init, then a long drain blocks two refreshes.
    rst = 0; init_done = 0; idle_inputs();
    step(); step();
    rst = 1;
    rd_req = 1; wr_req = 1;
    bad = 0; bad2 = 0;
    for (int k = 0; k < 2 * RI + 5; k++) begin
      step();
      if (rd_en || wr_en || busy || command !== NOP) bad++;
      if (ref_overrun) bad2++;
    end
    chk("init_no_grant", 32'(bad), 0);
    chk("init_no_ovr", 32'(bad2), 0);
    init_done = 1; wr_req = 0;
    step();
    chk("ovr_grant", 32'(rd_en), 1);
    rd_req = 0; rd_ready = 0;
    step();
    chk("ovr_drain_busy", 32'(busy), 1);
    chk("ovr_clear_early", 32'(ref_overrun), 0);
    for (int k = 0; k < 2 * RI + 5; k++) step();
    chk("ovr_still_drain", 32'(busy), 1);
    chk("ovr_set", 32'(ref_overrun), 1);
    rd_ready = 1;
    step(); step(); step();
    chk("ovr_sticky", 32'(ref_overrun), 1);

    // Reset asserted mid-write.
    do_reset(1'b1);
    wr_req = 1; wr_command = 3'b010;
    wr_addr = 12'h5a5; wr_bank = 2'd2;
    step();
    step();
    chk("mid_wr_en", 32'(wr_en), 1);
    chk("mid_wr_cmd", 32'(command), 32'h2);
    rst = 0;
    step();
    chk("mid_rst_wr_en", 32'(wr_en), 0);
    chk("mid_rst_cmd", 32'(command), 32'(NOP));
    chk("mid_rst_addr", 32'(addr), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    rst = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  always @(negedge clk) begin
    if (rst && rd_en && wr_en) begin
      failures++;
      $display("FAIL both_en actual=1 required=0");
    end
  end

endmodule
